// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Merges load-use, taken-branch and data-memory wait into stage controls.
//
// Ports:
//   clk, rst           clock, async active-high reset
//   Rt_addr_IE         rt (dest) of the EX instruction
//   Rs_addr, Rt_addr   sources of the ID instruction
//   MemRead_IE         EX instruction is a load
//   Branch_taken_EX    EX branch resolved taken
//   mem_req, mem_ready MEM-stage data memory handshake
//   clr_cnt            synchronous clear of the perf counters
//   PCWrite..MEM_WB_Bubble  per-stage enables / nop loads
//   mem_err            sticky memory-wait watchdog error
//   stall_cnt          cycles with PCWrite=0 (saturating)
//   flush_cnt          taken-branch flush cycles (saturating)

module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rt_addr_IE,
  input  logic [4:0]       Rs_addr,
  input  logic [4:0]       Rt_addr,
  input  logic             MemRead_IE,
  input  logic             Branch_taken_EX,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             clr_cnt,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             ID_EX_Write,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  typedef enum logic {
    S_RUN,
    S_ERR
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WC_W-1:0]  r_wcnt;
  logic [WC_W-1:0]  w_wcnt_nxt;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_load_use;
  logic w_mem_wait;
  logic w_freeze;
  logic w_flush;
  logic w_stall;
  logic w_run;
  logic w_trip;

  logic w_pc;
  logic w_ifid_w;
  logic w_ifid_f;
  logic w_idex_f;
  logic w_idex_w;
  logic w_exmem_w;
  logic w_bubble;

  // r0 is hardwired zero, so a load to it never creates a hazard.
  assign w_load_use = MemRead_IE
                    && (Rt_addr_IE != 5'd0)
                    && ((Rt_addr_IE == Rs_addr)
                     || (Rt_addr_IE == Rt_addr));

  assign w_mem_wait = mem_req && !mem_ready;

  // One-hot mode decode, priority: freeze > flush > stall > run.
  // Flush beats load-use since the ID instruction is wrong-path.
  assign w_freeze = (r_state == S_ERR) || w_mem_wait;
  assign w_flush  = !w_freeze && Branch_taken_EX;
  assign w_stall  = !w_freeze && !Branch_taken_EX && w_load_use;
  assign w_run    = !w_freeze && !Branch_taken_EX && !w_load_use;

  // Trips on the TIMEOUT-th consecutive wait, not when ready
  // arrives on that cycle.
  assign w_trip = (r_state == S_RUN) && w_mem_wait
               && (r_wcnt == WC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = '0;
    unique case (r_state)
      S_RUN: begin
        if (w_trip) begin
          w_state_nxt = S_ERR;
        end else if (w_mem_wait) begin
          w_wcnt_nxt = r_wcnt + 1'b1;
        end
      end
      S_ERR: begin
        w_state_nxt = S_ERR;
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  always_comb begin
    w_pc      = 1'b0;
    w_ifid_w  = 1'b0;
    w_ifid_f  = 1'b0;
    w_idex_f  = 1'b0;
    w_idex_w  = 1'b0;
    w_exmem_w = 1'b0;
    w_bubble  = 1'b0;
    unique case (1'b1)
      w_freeze: begin
        w_bubble = 1'b1;
      end
      w_flush: begin
        w_pc      = 1'b1;
        w_ifid_w  = 1'b1;
        w_ifid_f  = 1'b1;
        w_idex_f  = 1'b1;
        w_idex_w  = 1'b1;
        w_exmem_w = 1'b1;
      end
      w_stall: begin
        w_idex_f  = 1'b1;
        w_idex_w  = 1'b1;
        w_exmem_w = 1'b1;
      end
      w_run: begin
        w_pc      = 1'b1;
        w_ifid_w  = 1'b1;
        w_idex_w  = 1'b1;
        w_exmem_w = 1'b1;
      end
      default: begin
        w_pc = 1'b0;
      end
    endcase
  end

  // Reset forces every control low immediately, not at the next edge.
  assign PCWrite       = !rst && w_pc;
  assign IF_ID_Write   = !rst && w_ifid_w;
  assign IF_ID_Flush   = !rst && w_ifid_f;
  assign ID_EX_Flush   = !rst && w_idex_f;
  assign ID_EX_Write   = !rst && w_idex_w;
  assign EX_MEM_Write  = !rst && w_exmem_w;
  assign MEM_WB_Bubble = !rst && w_bubble;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_err <= 1'b0;
    end else if (w_trip) begin
      r_mem_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (clr_cnt) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pc && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed + random checks of pipe_hazard_ctrl
// against a behavioural model of the hazard priority rules.

module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_FLUSH  = 7'b1111110;
  localparam logic [6:0] C_STALL  = 7'b0001110;
  localparam logic [6:0] C_RUN    = 7'b1100110;

  logic             clk;
  logic             rst;
  logic [4:0]       Rt_addr_IE;
  logic [4:0]       Rs_addr;
  logic [4:0]       Rt_addr;
  logic             MemRead_IE;
  logic             Branch_taken_EX;
  logic             mem_req;
  logic             mem_ready;
  logic             clr_cnt;
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic             ID_EX_Write;
  logic             EX_MEM_Write;
  logic             MEM_WB_Bubble;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int checks;
  int failures;

  int m_wait;
  int m_err;
  int m_stall;
  int m_flush;

  pipe_hazard_ctrl #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .Rt_addr_IE     (Rt_addr_IE),
    .Rs_addr        (Rs_addr),
    .Rt_addr        (Rt_addr),
    .MemRead_IE     (MemRead_IE),
    .Branch_taken_EX(Branch_taken_EX),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .clr_cnt        (clr_cnt),
    .PCWrite        (PCWrite),
    .IF_ID_Write    (IF_ID_Write),
    .IF_ID_Flush    (IF_ID_Flush),
    .ID_EX_Flush    (ID_EX_Flush),
    .ID_EX_Write    (ID_EX_Write),
    .EX_MEM_Write   (EX_MEM_Write),
    .MEM_WB_Bubble  (MEM_WB_Bubble),
    .mem_err        (mem_err),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ctrl_vec();
    return {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
            ID_EX_Write, EX_MEM_Write, MEM_WB_Bubble};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".err"}, 32'(mem_err), 32'(m_err));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
  endtask

  // Inputs change at posedge+1, checks at posedge+2.
  task automatic step(input string tag,
                      input logic mr, input logic [4:0] rtie,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic br, input logic mq,
                      input logic rdy, input logic clr);
    logic [6:0] exp;
    bit lu;
    bit frz;
    MemRead_IE      = mr;
    Rt_addr_IE      = rtie;
    Rs_addr         = rs;
    Rt_addr         = rt;
    Branch_taken_EX = br;
    mem_req         = mq;
    mem_ready       = rdy;
    clr_cnt         = clr;
    #1;
    lu  = mr && rtie != 0 && (rtie == rs || rtie == rt);
    frz = (m_err != 0) || (mq && !rdy);
    if (frz)     exp = C_FREEZE;
    else if (br) exp = C_FLUSH;
    else if (lu) exp = C_STALL;
    else         exp = C_RUN;
    chk({tag, ".ctrl"}, 32'(ctrl_vec()), 32'(exp));
    chk_regs(tag);
    @(posedge clk);
    if (clr) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (exp[6] == 1'b0 && m_stall < CMAX) m_stall++;
      if (exp == C_FLUSH && m_flush < CMAX) m_flush++;
    end
    if (m_err == 0) begin
      if (mq && !rdy) begin
        m_wait++;
        if (m_wait == TIMEOUT) m_err = 1;
      end else begin
        m_wait = 0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    MemRead_IE      = 1'b0;
    Rt_addr_IE      = 5'd0;
    Rs_addr         = 5'd0;
    Rt_addr         = 5'd0;
    Branch_taken_EX = 1'b0;
    mem_req         = 1'b0;
    mem_ready       = 1'b0;
    clr_cnt         = 1'b0;
  endtask

  // Asserts rst mid-cycle with the current inputs still applied.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    m_wait  = 0;
    m_err   = 0;
    m_stall = 0;
    m_flush = 0;
    chk({tag, ".rst_ctrl"}, 32'(ctrl_vec()), 32'd0);
    chk_regs({tag, ".rst"});
    idle_inputs();
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_wait   = 0;
    m_err    = 0;
    m_stall  = 0;
    m_flush  = 0;
    rst      = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    do_reset("init");

    step("run0", 0, 0, 0, 0, 0, 0, 0, 0);
    step("lu",   1, 5, 5, 0, 0, 0, 0, 0);
    step("lu_after", 0, 0, 0, 0, 0, 0, 0, 0);
    step("lu_r0", 1, 0, 0, 0, 0, 0, 0, 0);
    step("lu_rt", 1, 7, 3, 7, 0, 0, 0, 0);
    step("br_lu", 1, 5, 5, 0, 1, 0, 0, 0);
    step("br_after", 0, 0, 0, 0, 0, 0, 0, 0);

    step("clr0", 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      step("mwait", 0, 0, 0, 0, 1, 1, 0, 0);
    step("mdone", 0, 0, 0, 0, 0, 1, 1, 0);
    step("mpost", 1, 2, 2, 0, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++)
      step("sat", 1, 9, 0, 9, 0, 0, 0, 0);
    step("sat_chk", 1, 9, 0, 9, 0, 0, 0, 0);
    step("clr_stall", 1, 9, 0, 9, 0, 0, 0, 1);
    step("clr_chk", 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < TIMEOUT - 1; i++)
      step("nt_wait", 0, 0, 0, 0, 0, 1, 0, 0);
    step("nt_rdy", 0, 0, 0, 0, 0, 1, 1, 0);
    step("nt_chk", 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < TIMEOUT + 1; i++)
      step("wd_wait", 0, 0, 0, 0, 0, 1, 0, 0);
    step("wd_rdy", 0, 0, 0, 0, 1, 1, 1, 0);
    step("wd_hold", 1, 4, 4, 0, 0, 0, 0, 0);
    do_reset("wd_rst");
    step("wd_run", 0, 0, 0, 0, 0, 0, 0, 0);

    step("ar_wait", 0, 0, 0, 0, 0, 1, 0, 0);
    MemRead_IE = 1'b0;
    mem_req    = 1'b1;
    mem_ready  = 1'b0;
    #2;
    do_reset("ar");
    step("ar_run", 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step("rnd",
             1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)),
             $urandom_range(0, 3) == 0,
             1'($urandom_range(0, 1)),
             $urandom_range(0, 2) != 0,
             $urandom_range(0, 15) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline stall/flush sequencer for the 5-stage MIPS datapath. Combines load-use hazard detection, taken-branch flushing in EX, and a multi-cycle data-memory wait handshake into one set of stage write-enable and flush controls. It also provides a memory-wait watchdog and saturating performance counters. It sits beside the pipeline registers and replaces the ad-hoc per-stage enables.

## Interface
Parameters:
- TIMEOUT, 64, maximum consecutive memory-wait cycles before the watchdog trips (≥2).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- Rt_addr_IE  in  5  destination (rt) of the instruction in EX.
- Rs_addr  in  5  rs of the instruction in ID.
- Rt_addr  in  5  rt of the instruction in ID.
- MemRead_IE  in  1  instruction in EX is a load.
- Branch_taken_EX  in  1  branch in EX resolved taken.
- mem_req  in  1  instruction in MEM accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- clr_cnt  in  1  synchronous clear of the performance counters.
- PCWrite  out  1  PC load enable.
- IF_ID_Write  out  1  IF/ID register enable.
- IF_ID_Flush  out  1  IF/ID register loads a nop.
- ID_EX_Flush  out  1  ID/EX register loads a nop (bubble).
- ID_EX_Write  out  1  ID/EX register enable.
- EX_MEM_Write  out  1  EX/MEM register enable.
- MEM_WB_Bubble  out  1  MEM/WB register loads a nop.
- mem_err  out  1  sticky watchdog error.
- stall_cnt  out  CNT_W  cycles with PCWrite=0.
- flush_cnt  out  CNT_W  taken-branch flush events.

## Operation
- States: RUN, ERR. The wait counter wcnt (width clog2(TIMEOUT)) counts consecutive freeze cycles.
- Conditions, in priority order:
  - rst high: all enables 0, flushes and bubble 0.
  - ERR: freeze.
  - mem_req && !mem_ready: freeze.
  - Branch_taken_EX: flush.
  - load-use: stall.
  - Otherwise: run.
- load-use = MemRead_IE && Rt_addr_IE≠0 && (Rt_addr_IE==Rs_addr || Rt_addr_IE==Rt_addr). Register 0 never stalls.
- Freeze: PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write = 0; MEM_WB_Bubble=1; flushes 0. A branch or load-use during freeze is ignored and re-evaluated once freeze ends, because the inputs are held by the frozen registers.
- Flush: PCWrite=1, IF_ID_Flush=1, ID_EX_Flush=1, all writes 1, bubble 0. Flush beats load-use because the ID instruction is wrong-path.
- Stall: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, ID_EX_Write=1, EX_MEM_Write=1, bubble 0.
- Run: all writes 1, flushes 0, bubble 0.
- Watchdog:
  - In RUN, wcnt increments on each mem-wait freeze cycle and clears to 0 on any non-freeze cycle.
  - When a freeze cycle occurs with wcnt==TIMEOUT-1, the next state is ERR and mem_err is set.
  - ERR is left only by rst. mem_err is cleared only by rst.
- Counters:
  - stall_cnt +1 per cycle with PCWrite=0 (stall, freeze, or ERR).
  - flush_cnt +1 per flush cycle.
  - Both saturate at all-ones.
  - clr_cnt zeroes both and beats the increment in the same cycle.

## Timing
- Control outputs are combinational from the current inputs plus the registered state, so hazard response has zero latency in the same cycle.
- mem_err, stall_cnt and flush_cnt are registered; they reflect an event one cycle after it.
- Reset values: state RUN, wcnt 0, mem_err 0, counters 0, all control outputs 0 while rst is high.
- After rst deasserts with idle inputs, the first cycle is run (all writes 1).
- mem_ready is sampled every cycle. A mem_req && mem_ready cycle is not a freeze: the pipeline advances and wcnt clears.
- A freeze of exactly TIMEOUT cycles with ready arriving in cycle TIMEOUT+1 still trips ERR. Ready arriving in cycle TIMEOUT (wcnt==TIMEOUT-1 but not freezing) does not trip.
- Asserting rst mid-wait or in ERR returns immediately (asynchronously) to the reset values.

## Test plan
- Load-use: MemRead_IE=1, Rt_addr_IE=5, Rs_addr=5 → one cycle of PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; stall_cnt goes 0→1. Repeat with Rt_addr_IE=0 → no stall.
- Branch plus load-use in the same cycle: Branch_taken_EX=1 with a matching load → IF_ID_Flush=ID_EX_Flush=1, PCWrite=1; flush_cnt +1; stall_cnt unchanged.
- Memory wait: mem_req=1 with mem_ready low for 3 cycles → 3 freeze cycles with MEM_WB_Bubble=1, then advance; stall_cnt=3; mem_err=0.
- Watchdog with TIMEOUT=4: mem_req=1, mem_ready=0 held for 5 cycles → mem_err=1, outputs stay frozen after mem_ready=1; rst restores run and mem_err=0.
- Saturation and clear, CNT_W=4: 20 stall cycles → stall_cnt=15. clr_cnt=1 together with a stall → stall_cnt=0.
- Async reset: assert rst between clock edges during a freeze → outputs go to 0 immediately and counters become 0.
